// File: rtl/seg7_scan2_if.sv
// Digit/segment bundle between the mod-60 counter side and the 2-digit scanner.
// master drives the BCD digits and blanking request; slave (the scanner)
// drives the display pins and the frame tick.
interface seg7_scan2_if;
  logic [3:0] bcd_lo;
  logic [3:0] bcd_hi;
  logic       blank_lz;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       frame_tick;

  modport master (
    output bcd_lo, bcd_hi, blank_lz,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  bcd_lo, bcd_hi, blank_lz,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan2.sv
// Two-digit multiplexed 7-segment driver. Both BCD digits are snapshotted at
// the start of every frame so a digit cannot change while it is being shown.
// Frame: units -> gap -> tens -> gap, with blank gaps to suppress ghosting.
module seg7_scan2 #(
  parameter int SCAN_DIV   = 1000,
  parameter int GAP_CYCLES = 16,
  parameter bit SEG_ALOW   = 1'b1,
  parameter bit AN_ALOW    = 1'b1
) (
  input  logic         clki,
  input  logic         rs,
  seg7_scan2_if.slave  bus
);

  localparam int MAX_DWELL = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int CW        = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
  localparam logic [CW-1:0] SCAN_LOAD = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam bit        HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [6:0] SEG_OFF = {7{SEG_ALOW}};
  localparam logic [1:0] AN_OFF  = {2{AN_ALOW}};
  // Logical one-hot digit selects, flipped to pin polarity with AN_OFF.
  localparam logic [1:0] AN_UNITS = 2'b01 ^ AN_OFF;
  localparam logic [1:0] AN_TENS  = 2'b10 ^ AN_OFF;

  typedef enum logic [1:0] {S_LO, S_GAP1, S_HI, S_GAP2} state_t;

  // Logical segment pattern (1 = lit, {g,f,e,d,c,b,a}); non-BCD shows '-'.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  state_t        state_q, state_d, nxt_state;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [3:0]    snap_lo_q, snap_lo_d;
  logic [3:0]    snap_hi_q, snap_hi_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q, frame_tick_d;

  // Next-state/output logic: hold while dwelling, otherwise advance and set
  // the outputs belonging to the state being entered.
  always_comb begin
    state_d      = state_q;
    nxt_state    = state_q;
    dwell_d      = dwell_q;
    snap_lo_d    = snap_lo_q;
    snap_hi_d    = snap_hi_q;
    seg_d        = seg_q;
    an_d         = an_q;
    dp_d         = SEG_ALOW;
    frame_tick_d = 1'b0;

    if (dwell_q != '0) begin
      dwell_d = dwell_q - 1'b1;
    end else begin
      // With no gap time the gap states are skipped; S_GAP2 is still the
      // reset state, from which the first frame starts.
      unique case (state_q)
        S_LO:    nxt_state = HAS_GAP ? S_GAP1 : S_HI;
        S_GAP1:  nxt_state = S_HI;
        S_HI:    nxt_state = HAS_GAP ? S_GAP2 : S_LO;
        default: nxt_state = S_LO;
      endcase
      state_d = nxt_state;

      unique case (nxt_state)
        S_LO: begin
          dwell_d      = SCAN_LOAD;
          snap_lo_d    = bus.bcd_lo;
          snap_hi_d    = bus.bcd_hi;
          seg_d        = decode(bus.bcd_lo) ^ SEG_OFF;
          an_d         = AN_UNITS;
          frame_tick_d = 1'b1;
        end
        S_HI: begin
          dwell_d = SCAN_LOAD;
          // blank_lz is taken live here, but the digit is the frame snapshot.
          if (bus.blank_lz && (snap_hi_q == 4'd0)) begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
          end else begin
            seg_d = decode(snap_hi_q) ^ SEG_OFF;
            an_d  = AN_TENS;
          end
        end
        default: begin
          dwell_d = GAP_LOAD;
          seg_d   = SEG_OFF;
          an_d    = AN_OFF;
        end
      endcase
    end
  end

  // State, dwell counter, snapshots and all outputs; reset blanks the display
  // at once and parks in S_GAP2 with zero dwell so the next edge starts a frame.
  always_ff @(posedge clki) begin
    if (!rs) begin
      state_q      <= S_GAP2;
      dwell_q      <= '0;
      snap_lo_q    <= 4'd0;
      snap_hi_q    <= 4'd0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      dp_q         <= SEG_ALOW;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      snap_lo_q    <= snap_lo_d;
      snap_hi_q    <= snap_hi_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan2.sv
// Bench for seg7_scan2: two builds (SCAN_DIV=4 with GAP_CYCLES=2 and 0) share
// the same stimulus. A frame-position model predicts every output each cycle;
// literal expectations at selected edges pin the model itself.
module tb_seg7_scan2;

  localparam int SCAN = 4;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic       clk;
  logic       rs;
  logic [3:0] bcd_lo;
  logic [3:0] bcd_hi;
  logic       blank_lz;

  int errors = 0;
  int checks = 0;
  int e = 0;  // edges since the last release of reset

  // Model state per build (0: with gaps, 1: gapless)
  logic [3:0] m_snap_lo [2];
  logic [3:0] m_snap_hi [2];
  logic       m_blank   [2];
  logic [6:0] m_seg     [2];
  logic [1:0] m_an      [2];
  logic       m_ft      [2];

  seg7_scan2_if bus_a();
  seg7_scan2_if bus_b();

  assign bus_a.bcd_lo   = bcd_lo;
  assign bus_a.bcd_hi   = bcd_hi;
  assign bus_a.blank_lz = blank_lz;
  assign bus_b.bcd_lo   = bcd_lo;
  assign bus_b.bcd_hi   = bcd_hi;
  assign bus_b.blank_lz = blank_lz;

  seg7_scan2 #(.SCAN_DIV(SCAN), .GAP_CYCLES(2), .SEG_ALOW(1'b1), .AN_ALOW(1'b1))
    dut_a (.clki(clk), .rs(rs), .bus(bus_a.slave));

  seg7_scan2 #(.SCAN_DIV(SCAN), .GAP_CYCLES(0), .SEG_ALOW(1'b1), .AN_ALOW(1'b1))
    dut_b (.clki(clk), .rs(rs), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, required %h", name, e, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    $display("edge %0d %s: got %h expect %h", e, name, act, exp);
    chk(name, act, exp);
  endtask

  // One clock: update the model at the rising edge from the inputs present
  // there, then compare both builds on the falling edge.
  task automatic tick();
    int g;
    int frame;
    int pos;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      g     = (i == 0) ? 2 : 0;
      frame = 2 * SCAN + 2 * g;
      if (!rs) begin
        m_snap_lo[i] = 4'd0;
        m_snap_hi[i] = 4'd0;
        m_seg[i]     = 7'h7F;
        m_an[i]      = 2'b11;
        m_ft[i]      = 1'b0;
      end else begin
        pos = e % frame;
        if (pos == 0) begin
          m_snap_lo[i] = bcd_lo;
          m_snap_hi[i] = bcd_hi;
        end
        m_ft[i]  = (pos == 0);
        m_seg[i] = 7'h7F;
        m_an[i]  = 2'b11;
        if (pos < SCAN) begin
          m_an[i]  = 2'b10;
          m_seg[i] = ~SEG_TAB[m_snap_lo[i]];
        end else if (pos >= SCAN + g && pos < 2 * SCAN + g) begin
          if (pos == SCAN + g) m_blank[i] = blank_lz;
          if (!(m_blank[i] && m_snap_hi[i] == 4'd0)) begin
            m_an[i]  = 2'b01;
            m_seg[i] = ~SEG_TAB[m_snap_hi[i]];
          end
        end
      end
    end
    if (!rs) e = 0;
    else     e++;
    @(negedge clk);
    chk("a.an",  {6'd0, bus_a.an},         {6'd0, m_an[0]});
    chk("a.seg", {1'b0, bus_a.seg},        {1'b0, m_seg[0]});
    chk("a.dp",  {7'd0, bus_a.dp},         8'd1);
    chk("a.ft",  {7'd0, bus_a.frame_tick}, {7'd0, m_ft[0]});
    chk("b.an",  {6'd0, bus_b.an},         {6'd0, m_an[1]});
    chk("b.seg", {1'b0, bus_b.seg},        {1'b0, m_seg[1]});
    chk("b.dp",  {7'd0, bus_b.dp},         8'd1);
    chk("b.ft",  {7'd0, bus_b.frame_tick}, {7'd0, m_ft[1]});
  endtask

  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (e < n && guard < 1000) begin
      tick();
      guard++;
    end
    chk("run_to_reached", (e == n) ? 8'd1 : 8'd0, 8'd1);
  endtask

  initial begin
    rs       = 1'b0;
    bcd_hi   = 4'd4;
    bcd_lo   = 4'd7;
    blank_lz = 1'b0;
    m_blank[0] = 1'b0;
    m_blank[1] = 1'b0;

    // Reset held for three clocks
    repeat (3) tick();
    lit("reset.an",  {6'd0, bus_a.an},         8'h03);
    lit("reset.seg", {1'b0, bus_a.seg},        8'h7F);
    lit("reset.dp",  {7'd0, bus_a.dp},         8'h01);
    lit("reset.ft",  {7'd0, bus_a.frame_tick}, 8'h00);

    // Normal frame, digits 4/7
    rs = 1'b1;
    tick();
    lit("e1.ft",  {7'd0, bus_a.frame_tick}, 8'h01);
    lit("e1.an",  {6'd0, bus_a.an},         8'h02);
    lit("e1.seg", {1'b0, bus_a.seg},        8'h78);
    run_to(2);
    bcd_lo = 4'd8;          // lands at edge 3: must not tear the units digit
    run_to(4);
    lit("e4.seg", {1'b0, bus_a.seg},        8'h78);
    run_to(5);
    lit("e5.an",   {6'd0, bus_a.an},        8'h03);
    lit("b.e5.an", {6'd0, bus_b.an},        8'h01);
    run_to(7);
    lit("e7.an",  {6'd0, bus_a.an},         8'h01);
    lit("e7.seg", {1'b0, bus_a.seg},        8'h19);
    run_to(9);
    lit("b.e9.ft", {7'd0, bus_b.frame_tick}, 8'h01);
    run_to(12);
    lit("e12.an", {6'd0, bus_a.an},         8'h03);
    lit("e12.ft", {7'd0, bus_a.frame_tick}, 8'h00);
    run_to(13);
    lit("e13.ft",  {7'd0, bus_a.frame_tick}, 8'h01);
    lit("e13.seg", {1'b0, bus_a.seg},        8'h00);
    run_to(25);
    lit("e25.ft", {7'd0, bus_a.frame_tick}, 8'h01);

    // Leading-zero blanking on, then off
    bcd_hi   = 4'd0;
    blank_lz = 1'b1;
    run_to(43);
    lit("lz1.an",  {6'd0, bus_a.an},  8'h03);
    lit("lz1.seg", {1'b0, bus_a.seg}, 8'h7F);
    blank_lz = 1'b0;
    run_to(55);
    lit("lz0.an",  {6'd0, bus_a.an},  8'h01);
    lit("lz0.seg", {1'b0, bus_a.seg}, 8'h40);

    // Non-BCD units digit shows '-'
    bcd_lo = 4'hC;
    run_to(61);
    lit("inv.seg", {1'b0, bus_a.seg}, 8'h3F);

    // Reset in the middle of the tens digit (frame-relative edge 8)
    run_to(67);
    rs     = 1'b0;
    bcd_lo = 4'd2;
    tick();
    lit("mid.an",  {6'd0, bus_a.an},         8'h03);
    lit("mid.seg", {1'b0, bus_a.seg},        8'h7F);
    lit("mid.ft",  {7'd0, bus_a.frame_tick}, 8'h00);
    rs = 1'b1;
    tick();
    lit("rel.ft",  {7'd0, bus_a.frame_tick}, 8'h01);
    lit("rel.an",  {6'd0, bus_a.an},         8'h02);
    lit("rel.seg", {1'b0, bus_a.seg},        8'h24);
    run_to(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
